// File: rtl/mux16_arbiter_pkg.sv
// Shared types and constants for the mux16 round-robin arbiter.
// State encoding and source IDs are used by RTL and bench alike.
package mux16_arbiter_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/mux16.sv
// Two-input word multiplexer shared by sources A and B.
// sel=0 passes a, sel=1 passes b.
module mux16 #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sel,
   output logic [DATA_W-1:0] out
);

   assign out = sel ? b : a;

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter for two sources sharing one mux16 datapath,
// with a single-entry valid/ready output register and grant counters.
module mux16_arbiter
   import mux16_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   input  logic              out_ready,
   output logic              sel,
   output logic [CNT_W-1:0]  cnt_a,
   output logic [CNT_W-1:0]  cnt_b
);

   state_t            state;
   logic              last_grant;
   logic              grant;
   logic              can_load;
   logic              xfer;
   logic [DATA_W-1:0] mux_out;

   // With no requester, grant stays on last_grant so sel does not toggle.
   always_comb begin
      grant = last_grant;
      if (a_valid && b_valid)
         grant = ~last_grant;
      else if (a_valid)
         grant = SRC_A;
      else if (b_valid)
         grant = SRC_B;
   end

   assign sel       = grant;
   assign out_valid = (state == ST_FULL);
   assign can_load  = (state == ST_EMPTY) || (out_ready && out_valid);

   assign a_ready = !reset && can_load && a_valid && (grant == SRC_A);
   assign b_ready = !reset && can_load && b_valid && (grant == SRC_B);
   assign xfer    = a_ready || b_ready;

   mux16 #(
      .DATA_W (DATA_W)
   ) u_mux (
      .a   (a_data),
      .b   (b_data),
      .sel (sel),
      .out (mux_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_EMPTY;
         out_data   <= '0;
         out_src    <= SRC_A;
         last_grant <= SRC_B;
         cnt_a      <= '0;
         cnt_b      <= '0;
      end else if (xfer) begin
         state      <= ST_FULL;
         out_data   <= mux_out;
         out_src    <= grant;
         last_grant <= grant;
         if (grant == SRC_A)
            cnt_a <= cnt_a + CNT_W'(1);
         else
            cnt_b <= cnt_b + CNT_W'(1);
      end else if (out_valid && out_ready) begin
         state <= ST_EMPTY;
      end
   end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Directed bench for mux16_arbiter: reset, fairness, backpressure,
// counter wrap (second instance with CNT_W=2) and reset while full.
module tb_mux16_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, out_ready;
   logic [15:0] a_data, b_data;
   logic        a_ready, b_ready, out_valid, out_src, sel;
   logic [15:0] out_data;
   logic [7:0]  cnt_a, cnt_b;

   logic        a_ready2, b_ready2, out_valid2, out_src2, sel2;
   logic [15:0] out_data2;
   logic [1:0]  cnt_a2, cnt_b2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux16_arbiter #(.DATA_W(16), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .sel       (sel),
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b)
   );

   mux16_arbiter #(.DATA_W(16), .CNT_W(2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready2),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready2),
      .out_valid (out_valid2),
      .out_data  (out_data2),
      .out_src   (out_src2),
      .out_ready (out_ready),
      .sel       (sel2),
      .cnt_a     (cnt_a2),
      .cnt_b     (cnt_b2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      logic [15:0] seq_exp;
      logic [1:0]  wrap_exp [5];
      wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // Reset with both sources requesting
      reset     = 1'b1;
      a_valid   = 1'b1;
      b_valid   = 1'b1;
      a_data    = 16'hAAAA;
      b_data    = 16'hBBBB;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cnt_b", cnt_b, 0);
      reset = 1'b0;
      #1;
      chk("first_a_ready", a_ready, 1);
      chk("first_b_ready", b_ready, 0);
      chk("first_sel", sel, 0);
      tick();
      chk("first_out_valid", out_valid, 1);
      chk("first_out_data", out_data, 16'hAAAA);
      chk("first_out_src", out_src, 0);

      // Fairness: strict alternation starting with A
      do_reset();
      a_data    = 16'h1234;
      b_data    = 16'h5678;
      a_valid   = 1'b1;
      b_valid   = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         seq_exp = (i % 2 == 0) ? 16'h1234 : 16'h5678;
         chk("rr_data", out_data, seq_exp);
         chk("rr_src", out_src, i % 2);
      end
      chk("rr_cnt_a", cnt_a, 3);
      chk("rr_cnt_b", cnt_b, 3);

      // B only, then drain to EMPTY
      do_reset();
      b_valid = 1'b1;
      b_data  = 16'h5555;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bonly_a_ready", a_ready, 0);
         chk("bonly_b_ready", b_ready, 1);
         tick();
         chk("bonly_data", out_data, 16'h5555);
      end
      chk("bonly_cnt_b", cnt_b, 4);
      chk("bonly_cnt_a", cnt_a, 0);
      b_valid = 1'b0;
      #1;
      chk("idle_sel_hold", sel, 1);
      tick();
      chk("drain_valid", out_valid, 0);
      chk("drain_data", out_data, 16'h5555);

      // Backpressure
      a_valid = 1'b1;
      a_data  = 16'hBEEF;
      tick();
      chk("bp_load", out_data, 16'hBEEF);
      a_valid   = 1'b0;
      b_valid   = 1'b1;
      b_data    = 16'h0F0F;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_b_ready", b_ready, 0);
         tick();
         chk("bp_hold_data", out_data, 16'hBEEF);
         chk("bp_hold_valid", out_valid, 1);
      end
      chk("bp_cnt_b", cnt_b, 4);
      out_ready = 1'b1;
      #1;
      chk("bp_release_b_ready", b_ready, 1);
      tick();
      chk("bp_release_data", out_data, 16'h0F0F);
      chk("bp_release_src", out_src, 1);
      chk("bp_release_valid", out_valid, 1);
      chk("bp_release_cnt_b", cnt_b, 5);

      // Counter wrap on the CNT_W=2 instance
      do_reset();
      a_valid = 1'b1;
      a_data  = 16'h0A0A;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wrap_cnt_a2", cnt_a2, wrap_exp[i]);
         chk("wide_cnt_a", cnt_a, i + 1);
      end
      chk("wrap_data2", out_data2, 16'h0A0A);

      // Reset while FULL
      do_reset();
      a_valid = 1'b1;
      a_data  = 16'hCAFE;
      tick();
      chk("cafe_load", out_data, 16'hCAFE);
      a_valid   = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("cafe_hold", out_data, 16'hCAFE);
      reset   = 1'b1;
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 16'h1111;
      b_data  = 16'h2222;
      #1;
      chk("rstfull_a_ready", a_ready, 0);
      tick();
      chk("rstfull_valid", out_valid, 0);
      chk("rstfull_data", out_data, 0);
      chk("rstfull_cnt_a", cnt_a, 0);
      chk("rstfull_cnt_b", cnt_b, 0);
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("tie_after_rst_sel", sel, 0);
      chk("tie_after_rst_a_ready", a_ready, 1);
      tick();
      chk("tie_after_rst_data", out_data, 16'h1111);
      chk("tie_after_rst_src", out_src, 0);
      chk("next_tie_sel", sel, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/mux16_arbiter.md
Name: mux16_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 16-bit mux16 datapath between sources A and B and drives its `sel`.
- The winning word is captured in a single-entry output register with a valid/ready handshake toward the consumer (CPU bus / register-file write port).
- Keeps per-source grant counters for debug and fairness checking.

Parameters:
- DATA_W, 16, width of request and output data; must match the mux16 width.
- CNT_W, 8, width of the per-source grant counters; counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  source A has a word pending.
- a_data  input  DATA_W  source A word.
- a_ready  output  1  source A word accepted this cycle (a_valid && a_ready = transfer).
- b_valid  input  1  source B has a word pending.
- b_data  input  DATA_W  source B word.
- b_ready  output  1  source B word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered output word.
- out_src  output  1  source of the held word (0 = A, 1 = B).
- out_ready  input  1  consumer accepts the word this cycle.
- sel  output  1  mux select driven into mux16 (0 = a_data, 1 = b_data); combinational grant.
- cnt_a  output  CNT_W  number of A transfers since reset.
- cnt_b  output  CNT_W  number of B transfers since reset.

Behaviour:
- Reset (synchronous, active-high, dominates everything): out_valid=0, out_data=0, out_src=0, last_grant=1 (so A wins the first tie), cnt_a=0, cnt_b=0.
  - a_ready=0 and b_ready=0 in any cycle where reset=1.
  - A word held in the output register at reset is discarded.
- State machine, 2 states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) || (out_ready && out_valid). A drain and a load may happen in the same cycle.
- Grant (combinational):
  - Only a_valid: grant A.
  - Only b_valid: grant B.
  - Both valid: grant the source opposite last_grant.
  - Neither valid: no grant; sel holds the previous last_grant value.
- sel = granted source.
- a_ready = can_load && grant A; b_ready = can_load && grant B. Ready never asserts for a source whose valid is low.
- On transfer:
  - out_data <= mux16 output.
  - out_src <= granted source.
  - last_grant <= granted source.
  - Granted counter increments by 1, wrapping from 2^CNT_W-1 to 0.
  - State -> FULL.
- Latency: an accepted word is visible on out_data/out_valid the cycle after the transfer.
- Throughput: one word per cycle while out_ready=1.
- FULL && !out_ready: the output register holds (out_data and out_src stable), both readies are 0, last_grant and counters are unchanged.
- FULL && out_ready && no requester valid: state -> EMPTY, out_data keeps its last value.
- Fairness: with both valid continuously and out_ready=1, grants strictly alternate A,B,A,B. No source waits more than one transfer.
- A requester must hold valid and data stable until ready; the arbiter does not check this.

Decomposition:
- Shared package holds:
  - State encoding constants ST_EMPTY=0, ST_FULL=1.
  - Source IDs SRC_A=0, SRC_B=1.
  - Default DATA_W=16.
- Sub-module: reuse the existing mux16 (a, b, sel, out) for the data path. Grant logic, output register and counters stay in this module.

Test Plan:
- Reset with a_valid=b_valid=1 -> a_ready=b_ready=0, out_valid=0, cnt_a=cnt_b=0. First cycle after reset: a_ready=1, sel=0. Next cycle: out_data=16'hAAAA (a_data), out_src=0.
- a_valid=b_valid=1 held, a_data=16'h1234, b_data=16'h5678, out_ready=1 for 6 cycles -> out_data sequence 1234, 5678, 1234, 5678, 1234, 5678; cnt_a=3, cnt_b=3.
- Only b_valid=1 (b_data=16'h5555), out_ready=1 for 4 cycles -> 4 B transfers, a_ready stays 0, cnt_b=4.
- Backpressure: load 16'hBEEF from A, then out_ready=0 for 5 cycles with b_valid=1 -> out_data stays BEEF, b_ready=0 throughout. Set out_ready=1 -> BEEF drains and B loads in the same cycle.
- Counter wrap: CNT_W=2, 5 A transfers -> cnt_a sequence 1,2,3,0,1.
- Assert reset while FULL (out_data=16'hCAFE, out_ready=0) -> next cycle out_valid=0, out_data=0, counters 0. First tie after reset grants A.
